any1_branch_sched: RTL and testbench
====================================

# any1_branch_sched

In-order branch resolution scheduler that shares a single `any1_eval_branch` comparator among queued branch operations. It buffers up to `NENT` issued branches with their operands and prediction, and evaluates the oldest one when the result slot is free. It registers the outcome (taken, mispredict, redirect PC) toward fetch and the reorder logic. On a mispredict it squashes all younger queued branches. The block sits between the issue stage and the fetch redirect and commit path.

## Interface

Parameters:
- `NENT`, 4: queue depth; power of two, 2..16.
- `TAGW`, 5: width of the reorder tag carried with each branch.

Ports:
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  asynchronous reset, active low.
- `flush_i`  in  1  pipeline flush; discards the queue and the result register.
- `req_valid_i`  in  1  branch offered.
- `req_ready_o`  out  1  queue can accept.
- `req_inst_i`  in  `$bits(Instruction)`  branch instruction; `br.opcode` selects the comparison.
- `req_a_i`, `req_b_i`  in  `$bits(Value)`  source operands; only `.val` (64 bits) is used.
- `req_tag_i`  in  `TAGW`  reorder tag.
- `req_pred_i`  in  1  predicted taken.
- `req_tgt_i`  in  64  taken target PC.
- `req_nxt_i`  in  64  fall-through PC.
- `res_valid_o`  out  1  result available.
- `res_ready_i`  in  1  result consumed.
- `res_tag_o`  out  `TAGW`  tag of the resolved branch.
- `res_takb_o`  out  1  branch is taken.
- `res_miss_o`  out  1  `res_takb_o != pred`.
- `res_pc_o`  out  64  correct next PC: `takb ? tgt : nxt`.
- `stat_br_o`, `stat_miss_o`  out  32 each  statistics counters (see Configuration).

## Operation

**Queue**
- Circular FIFO with `NENT` entries.
- Head and tail pointers are `$clog2(NENT)` bits and wrap modulo `NENT`.
- Occupancy `count` is `$clog2(NENT)+1` bits.
- Push occurs on `req_valid_i & req_ready_o`.
- `req_ready_o = (count != NENT)` is registered-state based. There is no same-cycle pop bypass, so a full queue refuses input even while it pops.

**Evaluation**
- The head entry drives the single comparator combinationally.
- Opcode semantics:
  - BEQ, BNE: equal / not equal.
  - BLT, BGE: signed compare.
  - BLTU, BGEU: unsigned compare.
  - BBS: `a[b[5:0]]`.
  - Any other opcode: not taken.

**Result register and FSM**
- `load = (count != 0) & (!res_valid_o | res_ready_i)`.
- On `load`, the head is popped and tag/takb/miss/pc are captured.
- States:
  - EMPTY: no valid result. Go to RESULT on `load`.
  - RESULT: `res_valid_o = 1`. On `res_ready_i`, go to RESULT if `load`, else EMPTY.
- Outputs are held stable while `res_valid_o & !res_ready_i`.

**Squash**
- When `load` captures a mispredict, all remaining queue entries are discarded at the same edge: count becomes 0 and the pointers are equalised.
- A push in that same cycle is also dropped, because it is wrong-path.
- The captured mispredicted result itself remains valid.

**Flush**
- `flush_i` at edge k leaves the queue empty and `res_valid_o = 0` after k.
- Flush has priority over push, pop and load.

**Reset**
- Asynchronous reset sets count, pointers and `res_valid_o` to 0.
- `res_tag_o`, `res_takb_o`, `res_miss_o` and `res_pc_o` reset to 0.
- `req_ready_o` reads 1 during and after reset.
- `stat_*` reset to 0.
- Reset asserted mid-operation discards everything immediately, without waiting for a clock.

## Timing

- Push at edge k sets `res_valid_o` after edge k+1 if the result slot is free.
- Minimum latency is 2 edges. Sustained throughput is 1 branch per cycle when `res_ready_i` is held high.
- A branch accepted into an empty queue is never evaluated in its own acceptance cycle; there is no queue bypass.
- Push and pop in the same cycle leave `count` unchanged.
- The miss/redirect outputs are valid in the same cycle as `res_valid_o`. Downstream samples them on the `res_valid_o & res_ready_i` edge.

## Configuration

- `ANY1_BRANCH_STATS_EN` defined:
  - `stat_br_o` increments on every `load`.
  - `stat_miss_o` increments on every `load` capturing a mispredict.
  - Both counters wrap at 2^32 and are cleared by reset only, not by flush.
- Not defined: both outputs are tied to 0 and no counter flops are built.

## Test plan

- **Basic:** reset, then push BEQ a=5 b=5 pred=1 tgt=0x1000 nxt=0x0FF4 tag=3.
  - After 2 edges: valid=1, tag=3, takb=1, miss=0, pc=0x1000.
- **Signed/unsigned:** push BLT a=0xFFFF_FFFF_FFFF_FFFF b=1, then BLTU with the same operands, `res_ready_i` held high.
  - Results on consecutive cycles: takb=1, then takb=0.
- **Backpressure/full:** `res_ready_i = 0`, push 5 branches with NENT=4.
  - First result loads; `req_ready_o` drops after the 5th push is accepted (4 queued + 1 in the result register).
  - Outputs stay stable. Releasing ready drains results in tag order.
- **Mispredict squash:** queue tags 1,2,3. Tag 1 is BNE a=b with pred=1.
  - Result tag=1, miss=1, pc=nxt. Tags 2 and 3 are never output.
  - A push in the squash cycle is dropped; the queue is empty afterwards.
- **Flush and reset mid-stream:** queue 3 entries, assert `flush_i` 1 cycle.
  - `res_valid_o = 0` and `req_ready_o = 1` next cycle.
  - Repeat with `rst_ni` pulsed low between edges: outputs clear asynchronously.
- **Stats (macro defined):** 10 branches, 3 mispredicted.
  - `stat_br_o = 10`, `stat_miss_o = 3`.
  - Without the macro, both read 0.

Source files
------------

// File: rtl/any1_branch_sched.sv
// any1 in-order branch resolution scheduler: FIFO of issued branches feeding one shared comparator.
// Optional statistics counters are built when ANY1_BRANCH_STATS_EN is defined.
package any1_pkg;
  typedef struct packed {
    logic [6:0] opcode;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [9:0] disp;
  } br_fmt_t;

  typedef struct packed {
    br_fmt_t br;
  } Instruction;

  typedef struct packed {
    logic        ok;
    logic [63:0] val;
  } Value;

  localparam logic [6:0] BEQ  = 7'h26;
  localparam logic [6:0] BNE  = 7'h27;
  localparam logic [6:0] BLT  = 7'h28;
  localparam logic [6:0] BGE  = 7'h29;
  localparam logic [6:0] BLTU = 7'h2A;
  localparam logic [6:0] BGEU = 7'h2B;
  localparam logic [6:0] BBS  = 7'h2C;
endpackage

module any1_eval_branch
  import any1_pkg::*;
(
  input  logic [6:0]  op,
  input  logic [63:0] a,
  input  logic [63:0] b,
  output logic        takb
);
  // Combinational branch condition decode
  always_comb begin
    takb = 1'b0;
    case (op)
      BEQ:     takb = (a == b);
      BNE:     takb = (a != b);
      BLT:     takb = ($signed(a) < $signed(b));
      BGE:     takb = ($signed(a) >= $signed(b));
      BLTU:    takb = (a < b);
      BGEU:    takb = (a >= b);
      BBS:     takb = a[b[5:0]];
      default: takb = 1'b0;
    endcase
  end
endmodule

module any1_branch_sched
  import any1_pkg::*;
#(
  parameter int NENT = 4,
  parameter int TAGW = 5
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  Instruction            req_inst_i,
  input  Value                  req_a_i,
  input  Value                  req_b_i,
  input  logic [TAGW-1:0]       req_tag_i,
  input  logic                  req_pred_i,
  input  logic [63:0]           req_tgt_i,
  input  logic [63:0]           req_nxt_i,
  output logic                  res_valid_o,
  input  logic                  res_ready_i,
  output logic [TAGW-1:0]       res_tag_o,
  output logic                  res_takb_o,
  output logic                  res_miss_o,
  output logic [63:0]           res_pc_o,
  output logic [31:0]           stat_br_o,
  output logic [31:0]           stat_miss_o
);
  localparam int PW = $clog2(NENT);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(NENT);

  localparam logic [0:0] EMPTY  = 1'b0;
  localparam logic [0:0] RESULT = 1'b1;

  typedef struct packed {
    logic [6:0]      op;
    logic [63:0]     a;
    logic [63:0]     b;
    logic [63:0]     tgt;
    logic [63:0]     nxt;
    logic [TAGW-1:0] tag;
    logic            pred;
  } ent_t;

  ent_t            q [NENT];
  logic [PW-1:0]   hd;
  logic [PW-1:0]   tl;
  logic [CW-1:0]   count;
  logic [0:0]      state;
  ent_t            he;
  logic            takb;
  logic            miss;
  logic            push;
  logic            ld;
  logic            squash;
  logic            unused_ok;

  assign unused_ok = ^{req_inst_i, req_a_i.ok, req_b_i.ok};

  assign he          = q[hd];
  assign req_ready_o = (count != FULL);
  assign res_valid_o = (state == RESULT);
  assign push        = req_valid_i & req_ready_o;
  assign ld          = (count != '0) & (!res_valid_o | res_ready_i) & !flush_i;
  assign miss        = takb ^ he.pred;
  assign squash      = ld & miss;

  any1_eval_branch u_eval (
    .op   (he.op),
    .a    (he.a),
    .b    (he.b),
    .takb (takb)
  );

  // Entry storage; wrong-path pushes during a squash are not written
  always_ff @(posedge clk_i) begin
    if (push & !squash & !flush_i) begin
      q[tl] <= '{op: req_inst_i.br.opcode, a: req_a_i.val,
                 b: req_b_i.val, tgt: req_tgt_i, nxt: req_nxt_i,
                 tag: req_tag_i, pred: req_pred_i};
    end
  end

  // Queue pointers and occupancy, with flush and squash clearing
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hd    <= '0;
      tl    <= '0;
      count <= '0;
    end else if (flush_i) begin
      hd    <= '0;
      tl    <= '0;
      count <= '0;
    end else if (squash) begin
      hd    <= hd + PW'(1);
      tl    <= hd + PW'(1);
      count <= '0;
    end else begin
      if (push) tl <= tl + PW'(1);
      if (ld)   hd <= hd + PW'(1);
      if (push & !ld)      count <= count + CW'(1);
      else if (!push & ld) count <= count - CW'(1);
    end
  end

  // Result slot state machine
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)               state <= EMPTY;
    else if (flush_i)          state <= EMPTY;
    else if (ld)               state <= RESULT;
    else if (res_ready_i)      state <= EMPTY;
  end

  // Result capture, held while the consumer stalls
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      res_tag_o  <= '0;
      res_takb_o <= 1'b0;
      res_miss_o <= 1'b0;
      res_pc_o   <= '0;
    end else if (ld) begin
      res_tag_o  <= he.tag;
      res_takb_o <= takb;
      res_miss_o <= miss;
      res_pc_o   <= takb ? he.tgt : he.nxt;
    end
  end

`ifdef ANY1_BRANCH_STATS_EN
  logic [31:0] br_q;
  logic [31:0] miss_q;

  // Branch and mispredict counters, cleared only by reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      br_q   <= '0;
      miss_q <= '0;
    end else if (ld) begin
      br_q <= br_q + 32'd1;
      if (miss) miss_q <= miss_q + 32'd1;
    end
  end

  assign stat_br_o   = br_q;
  assign stat_miss_o = miss_q;
`else
  assign stat_br_o   = '0;
  assign stat_miss_o = '0;
`endif
endmodule

// File: tb/tb_any1_branch_sched.sv
// Directed bench for any1_branch_sched.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_any1_branch_sched;
  import any1_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        req_valid;
  logic        req_ready;
  Instruction  req_inst;
  Value        req_a;
  Value        req_b;
  logic [4:0]  req_tag;
  logic        req_pred;
  logic [63:0] req_tgt;
  logic [63:0] req_nxt;
  logic        res_valid;
  logic        res_ready;
  logic [4:0]  res_tag;
  logic        res_takb;
  logic        res_miss;
  logic [63:0] res_pc;
  logic [31:0] stat_br;
  logic [31:0] stat_miss;

  int nchk = 0;
  int npass = 0;

  always #5 clk = ~clk;

  any1_branch_sched #(.NENT(4), .TAGW(5)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .flush_i     (flush),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_inst_i  (req_inst),
    .req_a_i     (req_a),
    .req_b_i     (req_b),
    .req_tag_i   (req_tag),
    .req_pred_i  (req_pred),
    .req_tgt_i   (req_tgt),
    .req_nxt_i   (req_nxt),
    .res_valid_o (res_valid),
    .res_ready_i (res_ready),
    .res_tag_o   (res_tag),
    .res_takb_o  (res_takb),
    .res_miss_o  (res_miss),
    .res_pc_o    (res_pc),
    .stat_br_o   (stat_br),
    .stat_miss_o (stat_miss)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    nchk++;
    if (got === exp) npass++;
    else $display("FAIL %s got=%0h want=%0h", tag, got, exp);
  endtask

  task automatic step;
    @(negedge clk);
  endtask

  task automatic drv(input logic [6:0] op, input logic [63:0] a,
                     input logic [63:0] b, input logic [4:0] tag,
                     input logic pred, input logic [63:0] tgt,
                     input logic [63:0] nxt);
    req_valid = 1'b1;
    req_inst = '0;
    req_inst.br.opcode = op;
    req_a = '0;
    req_a.val = a;
    req_b = '0;
    req_b.val = b;
    req_tag = tag;
    req_pred = pred;
    req_tgt = tgt;
    req_nxt = nxt;
  endtask

  task automatic idle;
    req_valid = 1'b0;
  endtask

  logic [6:0]  v_op   [10];
  logic [63:0] v_a    [10];
  logic [63:0] v_b    [10];
  logic        v_pred [10];
  logic        v_takb [10];

  initial begin
    v_op = '{BEQ, BNE, BGE, BGEU, BBS, BBS, BLT, 7'h7F, BLTU, BNE};
    v_a  = '{64'd5, 64'd5, '1, '1, 64'h10, 64'h10, 64'd3, 64'd1,
             64'd1, 64'd4};
    v_b  = '{64'd5, 64'd6, 64'd1, 64'd1, 64'd4, 64'h43, 64'd7, 64'd1,
             64'd2, 64'd4};
    v_pred = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
               1'b0};
    v_takb = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1,
               1'b0};

    rst_n = 1'b0;
    flush = 1'b0;
    res_ready = 1'b0;
    req_valid = 1'b0;
    req_inst = '0;
    req_a = '0;
    req_b = '0;
    req_tag = '0;
    req_pred = 1'b0;
    req_tgt = '0;
    req_nxt = '0;
    step;
    chk("rst_ready", 64'(req_ready), 64'd1);
    rst_n = 1'b1;
    step;
    chk("rst_valid", 64'(res_valid), 64'd0);
    chk("rst_tag", 64'(res_tag), 64'd0);
    chk("rst_pc", res_pc, 64'd0);
    chk("rst_stat_br", 64'(stat_br), 64'd0);

    // basic BEQ
    drv(BEQ, 64'd5, 64'd5, 5'd3, 1'b1, 64'h1000, 64'h0FF4);
    step;
    idle;
    chk("lat1_valid", 64'(res_valid), 64'd0);
    step;
    chk("basic_valid", 64'(res_valid), 64'd1);
    chk("basic_tag", 64'(res_tag), 64'd3);
    chk("basic_takb", 64'(res_takb), 64'd1);
    chk("basic_miss", 64'(res_miss), 64'd0);
    chk("basic_pc", res_pc, 64'h1000);
    res_ready = 1'b1;
    step;
    chk("basic_drain", 64'(res_valid), 64'd0);

    // signed vs unsigned back to back
    drv(BLT, '1, 64'd1, 5'd4, 1'b1, 64'h2000, 64'h2004);
    step;
    drv(BLTU, '1, 64'd1, 5'd5, 1'b0, 64'h3000, 64'h3004);
    step;
    idle;
    chk("blt_tag", 64'(res_tag), 64'd4);
    chk("blt_takb", 64'(res_takb), 64'd1);
    step;
    chk("bltu_valid", 64'(res_valid), 64'd1);
    chk("bltu_tag", 64'(res_tag), 64'd5);
    chk("bltu_takb", 64'(res_takb), 64'd0);
    chk("bltu_pc", res_pc, 64'h3004);
    step;
    chk("su_drain", 64'(res_valid), 64'd0);

    // backpressure and full
    res_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp_ready%0d", i), 64'(req_ready), 64'd1);
      drv(BEQ, 64'd9, 64'd9, 5'(10 + i), 1'b1, 64'(16'h4000 + i),
          64'h5000);
      step;
    end
    idle;
    chk("full_ready", 64'(req_ready), 64'd0);
    chk("full_tag", 64'(res_tag), 64'd10);
    step;
    step;
    chk("hold_valid", 64'(res_valid), 64'd1);
    chk("hold_tag", 64'(res_tag), 64'd10);
    chk("hold_pc", res_pc, 64'h4000);
    res_ready = 1'b1;
    for (int i = 1; i < 5; i++) begin
      step;
      chk($sformatf("drain_tag%0d", i), 64'(res_tag), 64'(10 + i));
    end
    chk("drain_ready", 64'(req_ready), 64'd1);
    step;
    chk("drain_empty", 64'(res_valid), 64'd0);

    // mispredict squash
    res_ready = 1'b0;
    drv(BEQ, 64'd1, 64'd1, 5'd0, 1'b1, 64'h6000, 64'h6004);
    step;
    drv(BNE, 64'd7, 64'd7, 5'd1, 1'b1, 64'h7000, 64'h7004);
    step;
    drv(BEQ, 64'd1, 64'd1, 5'd2, 1'b1, 64'h8000, 64'h8004);
    step;
    drv(BEQ, 64'd1, 64'd1, 5'd3, 1'b1, 64'h9000, 64'h9004);
    step;
    chk("sq_hold_tag", 64'(res_tag), 64'd0);
    res_ready = 1'b1;
    drv(BEQ, 64'd1, 64'd1, 5'd4, 1'b1, 64'hA000, 64'hA004);
    step;
    idle;
    chk("sq_valid", 64'(res_valid), 64'd1);
    chk("sq_tag", 64'(res_tag), 64'd1);
    chk("sq_miss", 64'(res_miss), 64'd1);
    chk("sq_takb", 64'(res_takb), 64'd0);
    chk("sq_pc", res_pc, 64'h7004);
    step;
    chk("sq_gone", 64'(res_valid), 64'd0);
    chk("sq_ready", 64'(req_ready), 64'd1);
    step;
    step;
    chk("sq_still", 64'(res_valid), 64'd0);

    // flush
    res_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drv(BEQ, 64'd2, 64'd2, 5'(20 + i), 1'b1, 64'hB000, 64'hB004);
      step;
    end
    idle;
    chk("fl_pre_tag", 64'(res_tag), 64'd20);
    flush = 1'b1;
    step;
    flush = 1'b0;
    chk("fl_valid", 64'(res_valid), 64'd0);
    chk("fl_ready", 64'(req_ready), 64'd1);
    step;
    chk("fl_empty", 64'(res_valid), 64'd0);

    // asynchronous reset mid-stream
    for (int i = 0; i < 3; i++) begin
      drv(BEQ, 64'd2, 64'd2, 5'(30 + i), 1'b1, 64'hC000, 64'hC004);
      step;
    end
    idle;
    chk("ar_pre_tag", 64'(res_tag), 64'd30);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid", 64'(res_valid), 64'd0);
    chk("ar_ready", 64'(req_ready), 64'd1);
    chk("ar_tag", 64'(res_tag), 64'd0);
    chk("ar_pc", res_pc, 64'd0);
    step;
    rst_n = 1'b1;
    step;
    chk("ar_after", 64'(res_valid), 64'd0);

    // ten isolated branches, three mispredicted
    res_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drv(v_op[i], v_a[i], v_b[i], 5'(i), v_pred[i],
          64'(32'h2_0000 + i * 16), 64'(32'h3_0000 + i * 16));
      step;
      idle;
      step;
      chk($sformatf("v%0d_takb", i), 64'(res_takb), 64'(v_takb[i]));
      chk($sformatf("v%0d_miss", i), 64'(res_miss),
          64'(v_takb[i] ^ v_pred[i]));
      chk($sformatf("v%0d_pc", i), res_pc,
          v_takb[i] ? 64'(32'h2_0000 + i * 16)
                    : 64'(32'h3_0000 + i * 16));
      step;
    end
`ifdef ANY1_BRANCH_STATS_EN
    chk("stat_br", 64'(stat_br), 64'd10);
    chk("stat_miss", 64'(stat_miss), 64'd3);
`else
    chk("stat_br", 64'(stat_br), 64'd0);
    chk("stat_miss", 64'(stat_miss), 64'd0);
`endif

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule
